// File: rtl/aes_round_ctrl.sv
// AES round sequencer. It streams blocks one at a time: load, then NR rounds, then hold until the sink takes the block.
// Latency: the block accepted in cycle t is first offered (out_valid) in cycle t+NR+1.
module aes_round_ctrl #(
    parameter int NR    = 10,
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_clear,
    input  logic             i_start,
    input  logic [CNT_W-1:0] i_num_blocks,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic             o_dp_load,
    output logic             o_dp_round_en,
    output logic             o_dp_last_round,
    output logic [3:0]       o_round_idx,
    output logic [7:0]       o_rcon,
    output logic [CNT_W-1:0] o_blk_cnt,
    output logic             o_busy,
    output logic             o_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_IN,
        S_ROUND,
        S_HOLD,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [3:0]       r_round_idx;
    logic [7:0]       r_rcon;
    logic [CNT_W-1:0] r_blk_cnt;
    logic [CNT_W-1:0] r_num_blocks;

    logic [7:0]       w_rcon_next;
    logic             w_last_round;
    logic [CNT_W-1:0] w_blk_cnt_inc;

    // GF(2^8) doubling: this produces the next AES round constant
    assign w_rcon_next   = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1B : 8'h00);
    assign w_last_round  = (r_round_idx == 4'(NR));
    assign w_blk_cnt_inc = r_blk_cnt + CNT_W'(1);

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_state      <= S_IDLE;
            r_round_idx  <= 4'd0;
            r_rcon       <= 8'h00;
            r_blk_cnt    <= '0;
            r_num_blocks <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_num_blocks <= i_num_blocks;
                        r_blk_cnt    <= '0;
                        r_state      <= (i_num_blocks != '0) ? S_WAIT_IN : S_DONE;
                    end
                end
                S_WAIT_IN: begin
                    if (i_in_valid) begin
                        r_round_idx <= 4'd1;
                        r_rcon      <= 8'h01;
                        r_state     <= S_ROUND;
                    end
                end
                S_ROUND: begin
                    if (w_last_round) begin
                        r_round_idx <= 4'd0;
                        r_rcon      <= 8'h00;
                        r_state     <= S_HOLD;
                    end else begin
                        r_round_idx <= r_round_idx + 4'd1;
                        r_rcon      <= w_rcon_next;
                    end
                end
                S_HOLD: begin
                    if (i_out_ready) begin
                        r_blk_cnt <= w_blk_cnt_inc;
                        r_state   <= (w_blk_cnt_inc == r_num_blocks) ? S_DONE : S_WAIT_IN;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Handshake outputs decode from state alone; only dp_load also looks at in_valid.
    assign o_in_ready      = (r_state == S_WAIT_IN);
    assign o_out_valid     = (r_state == S_HOLD);
    assign o_dp_load       = (r_state == S_WAIT_IN) && i_in_valid;
    assign o_dp_round_en   = (r_state == S_ROUND);
    assign o_dp_last_round = (r_state == S_ROUND) && w_last_round;
    assign o_round_idx     = r_round_idx;
    assign o_rcon          = r_rcon;
    assign o_blk_cnt       = r_blk_cnt;
    assign o_busy          = (r_state != S_IDLE);
    assign o_done          = (r_state == S_DONE);

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl: a cycle table for a single-block job, plus hand sequences for the multi-cycle corner cases.
module tb_aes_round_ctrl;
    localparam int NR    = 10;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             i_reset, i_clear, i_start, i_in_valid, i_out_ready;
    logic [CNT_W-1:0] i_num_blocks;
    logic             o_in_ready, o_out_valid, o_dp_load, o_dp_round_en, o_dp_last_round;
    logic [3:0]       o_round_idx;
    logic [7:0]       o_rcon;
    logic [CNT_W-1:0] o_blk_cnt;
    logic             o_busy, o_done;

    always #5 clk = ~clk;

    aes_round_ctrl #(.NR(NR), .CNT_W(CNT_W)) dut (
        .i_clk(clk), .i_reset(i_reset), .i_clear(i_clear), .i_start(i_start),
        .i_num_blocks(i_num_blocks), .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
        .o_out_valid(o_out_valid), .i_out_ready(i_out_ready), .o_dp_load(o_dp_load),
        .o_dp_round_en(o_dp_round_en), .o_dp_last_round(o_dp_last_round),
        .o_round_idx(o_round_idx), .o_rcon(o_rcon), .o_blk_cnt(o_blk_cnt),
        .o_busy(o_busy), .o_done(o_done)
    );

    // Packed layout: busy,in_ready,dp_load,round_en,last,out_valid,done,round_idx[4],rcon[8],blk_cnt[16]
    typedef struct {
        logic             start;
        logic [CNT_W-1:0] nb;
        logic             iv;
        logic             ordy;
        logic [34:0]      exp;
    } vec_t;

    vec_t        vt[15];
    logic [7:0]  rc_tab[10];
    int          checks = 0;
    int          errors = 0;
    int          hold_len, nholds, loads, dones, ovl, t_load, fin_blk, t_done;
    int          hl[3];
    logic        done_seen, prev_rh;

    function automatic logic [34:0] mk(input logic bz, input logic inr, input logic ld,
                                        input logic ren, input logic lst, input logic ov,
                                        input logic dn, input logic [3:0] ri,
                                        input logic [7:0] rc, input logic [15:0] bc);
        return {bz, inr, ld, ren, lst, ov, dn, ri, rc, bc};
    endfunction

    function automatic logic [34:0] obs();
        return {o_busy, o_in_ready, o_dp_load, o_dp_round_en, o_dp_last_round, o_out_valid,
                o_done, o_round_idx, o_rcon, o_blk_cnt};
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rc_tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};
        vt[0] = '{1'b1, 16'd1, 1'b1, 1'b1, mk(0, 0, 0, 0, 0, 0, 0, 4'd0, 8'h00, 16'd0)};
        vt[1] = '{1'b0, 16'd1, 1'b1, 1'b1, mk(1, 1, 1, 0, 0, 0, 0, 4'd0, 8'h00, 16'd0)};
        for (int k = 1; k <= 10; k++)
            vt[1+k] = '{1'b0, 16'd1, 1'b1, 1'b1,
                        mk(1, 0, 0, 1, (k == 10), 0, 0, 4'(k), rc_tab[k-1], 16'd0)};
        vt[12] = '{1'b0, 16'd1, 1'b1, 1'b1, mk(1, 0, 0, 0, 0, 1, 0, 4'd0, 8'h00, 16'd0)};
        vt[13] = '{1'b0, 16'd1, 1'b1, 1'b1, mk(1, 0, 0, 0, 0, 0, 1, 4'd0, 8'h00, 16'd1)};
        vt[14] = '{1'b0, 16'd1, 1'b1, 1'b1, mk(0, 0, 0, 0, 0, 0, 0, 4'd0, 8'h00, 16'd1)};

        i_reset = 1'b1; i_clear = 1'b0; i_start = 1'b0; i_num_blocks = '0;
        i_in_valid = 1'b0; i_out_ready = 1'b0;
        repeat (3) cyc();
        @(negedge clk);
        chk("reset_state", obs(), 35'd0);
        cyc();
        i_reset = 1'b0;

        // Single block with source and sink always ready, checked cycle by cycle
        for (int r = 0; r < 15; r++) begin
            i_start = vt[r].start; i_num_blocks = vt[r].nb;
            i_in_valid = vt[r].iv; i_out_ready = vt[r].ordy;
            @(negedge clk);
            chk($sformatf("vec%0d", r), obs(), vt[r].exp);
            cyc();
        end

        // Zero-block job
        i_start = 1'b1; i_num_blocks = '0; i_in_valid = 1'b1;
        @(negedge clk);
        chk("zero_idle_busy", o_busy, 0);
        cyc();
        i_start = 1'b0;
        @(negedge clk);
        chk("zero_busy", o_busy, 1);
        chk("zero_done", o_done, 1);
        chk("zero_no_in_ready", o_in_ready, 0);
        chk("zero_no_load", o_dp_load, 0);
        cyc();
        @(negedge clk);
        chk("zero_back_idle", {o_busy, o_done}, 0);
        cyc();

        // A clear in the same cycle as start wins
        i_start = 1'b1; i_num_blocks = 16'd1; i_clear = 1'b1;
        cyc();
        i_start = 1'b0; i_clear = 1'b0;
        @(negedge clk);
        chk("clear_beats_start", o_busy, 0);
        cyc();

        // Three blocks, sink stalls 5 cycles per block, stray starts during ROUND/HOLD
        i_start = 1'b1; i_num_blocks = 16'd3; i_in_valid = 1'b1; i_out_ready = 1'b0;
        cyc();
        i_start = 1'b0;
        hold_len = 0; nholds = 0; loads = 0; dones = 0; ovl = 0; t_load = 0; fin_blk = 0;
        done_seen = 1'b0; prev_rh = 1'b0;
        for (int c = 0; c < 300 && !done_seen; c++) begin
            i_out_ready  = (hold_len == 5);
            i_start      = prev_rh;
            i_num_blocks = prev_rh ? 16'd7 : 16'd3;
            @(negedge clk);
            if (o_in_ready && o_out_valid) ovl++;
            if (o_dp_load) begin loads++; t_load = c; end
            if (o_done) begin dones++; done_seen = 1'b1; fin_blk = int'(o_blk_cnt); end
            if (o_out_valid) begin
                if (hold_len == 0) chk("latency", c - t_load, NR + 1);
                hold_len++;
            end else if (hold_len != 0) begin
                if (nholds < 3) hl[nholds] = hold_len;
                nholds++;
                hold_len = 0;
            end
            prev_rh = o_dp_round_en || o_out_valid;
            cyc();
        end
        i_start = 1'b0; i_out_ready = 1'b1;
        chk("multi_timeout", done_seen, 1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (o_done) dones++;
            cyc();
        end
        chk("multi_done_once", dones, 1);
        chk("multi_blk_cnt", fin_blk, 3);
        chk("multi_loads", loads, 3);
        chk("multi_overlap", ovl, 0);
        chk("multi_nholds", nholds, 3);
        for (int h = 0; h < 3; h++) chk($sformatf("hold_len%0d", h), hl[h], 6);

        // Reset during round 5 of the second block
        i_start = 1'b1; i_num_blocks = 16'd2; i_in_valid = 1'b1; i_out_ready = 1'b1;
        cyc();
        i_start = 1'b0; loads = 0; done_seen = 1'b0;
        for (int c = 0; c < 100 && !done_seen; c++) begin
            @(negedge clk);
            if (o_dp_load) loads++;
            if (loads == 2 && o_round_idx == 4'd5 && o_dp_round_en) begin
                i_reset = 1'b1;
                done_seen = 1'b1;
            end
            cyc();
        end
        chk("abort_reached_r5", done_seen, 1);
        i_reset = 1'b0;
        @(negedge clk);
        chk("abort_all_zero", obs(), 35'd0);
        dones = 0;
        for (int c = 0; c < 20; c++) begin
            cyc();
            @(negedge clk);
            if (o_done || o_busy) dones++;
        end
        chk("abort_no_done", dones, 0);
        cyc();

        // A fresh job after the abort runs normally
        i_start = 1'b1; i_num_blocks = 16'd1; t_done = -1; fin_blk = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (o_done) begin t_done = c; fin_blk = int'(o_blk_cnt); break; end
            cyc();
            i_start = 1'b0;
        end
        i_start = 1'b0;
        chk("rerun_done_time", t_done, NR + 3);
        chk("rerun_blk_cnt", fin_blk, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
